// File: rtl/axi_rr_arbiter.sv
// Purpose : merges N_PORTS AXI4 requesters onto one AXI4 master port with round-robin fairness; one read or write in flight.
// Latency : one cycle of arbitration (IDLE), then AR->R or W->B with no added registers in any channel.
// Backpress: readies/valids are combinational from the master side; ungranted ports see 0 and hold their requests.
//
// Ports: clock/reset (async, active-low); per-port AR/R/AW/W/B channels (flattened, port p in slice p);
//        shared rdata_o/rresp_o/bresp_o; io_master_* is the single downstream AXI4 master.
module axi_rr_arbiter #(
    parameter int N_PORTS = 2,
    parameter int DATA_W  = 32
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic [N_PORTS-1:0]            arvalid_i,
    output logic [N_PORTS-1:0]            arready_o,
    input  logic [N_PORTS*32-1:0]         araddr_i,
    input  logic [N_PORTS*3-1:0]          arsize_i,
    output logic [N_PORTS-1:0]            rvalid_o,
    input  logic [N_PORTS-1:0]            rready_i,
    output logic [DATA_W-1:0]             rdata_o,
    output logic [1:0]                    rresp_o,

    input  logic [N_PORTS-1:0]            awvalid_i,
    output logic [N_PORTS-1:0]            awready_o,
    input  logic [N_PORTS*32-1:0]         awaddr_i,
    input  logic [N_PORTS*3-1:0]          awsize_i,
    input  logic [N_PORTS-1:0]            wvalid_i,
    output logic [N_PORTS-1:0]            wready_o,
    input  logic [N_PORTS*DATA_W-1:0]     wdata_i,
    input  logic [N_PORTS*(DATA_W/8)-1:0] wstrb_i,
    output logic [N_PORTS-1:0]            bvalid_o,
    input  logic [N_PORTS-1:0]            bready_i,
    output logic [1:0]                    bresp_o,

    input  logic                          io_master_awready,
    output logic                          io_master_awvalid,
    output logic [31:0]                   io_master_awaddr,
    output logic [3:0]                    io_master_awid,
    output logic [7:0]                    io_master_awlen,
    output logic [2:0]                    io_master_awsize,
    output logic [1:0]                    io_master_awburst,
    input  logic                          io_master_wready,
    output logic                          io_master_wvalid,
    output logic [DATA_W-1:0]             io_master_wdata,
    output logic [(DATA_W/8)-1:0]         io_master_wstrb,
    output logic                          io_master_wlast,
    output logic                          io_master_bready,
    input  logic                          io_master_bvalid,
    input  logic [1:0]                    io_master_bresp,
    input  logic [3:0]                    io_master_bid,
    input  logic                          io_master_arready,
    output logic                          io_master_arvalid,
    output logic [31:0]                   io_master_araddr,
    output logic [3:0]                    io_master_arid,
    output logic [7:0]                    io_master_arlen,
    output logic [2:0]                    io_master_arsize,
    output logic [1:0]                    io_master_arburst,
    output logic                          io_master_rready,
    input  logic                          io_master_rvalid,
    input  logic [1:0]                    io_master_rresp,
    input  logic [DATA_W-1:0]             io_master_rdata,
    input  logic                          io_master_rlast,
    input  logic [3:0]                    io_master_rid
);

    localparam int GW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_W, ST_B} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;

    logic [N_PORTS-1:0] req;
    logic [GW-1:0]      pick;
    logic               pick_vld;
    logic [GW:0]        rr_idx;
    logic [GW-1:0]      grant_inc;
    logic [3:0]         id_ext;
    logic               r_hs, aw_hs, w_hs, b_hs;

    assign req       = arvalid_i | awvalid_i;
    assign id_ext    = 4'(grant_q);
    assign grant_inc = (grant_q == GW'(N_PORTS - 1)) ? '0 : grant_q + GW'(1);

    // Scan offsets from the highest down so the nearest requester at or after
    // rr_ptr overwrites any farther one; the index wraps modulo N_PORTS.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        rr_idx   = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            rr_idx = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (rr_idx >= (GW+1)'(N_PORTS)) begin
                rr_idx = rr_idx - (GW+1)'(N_PORTS);
            end
            if (req[rr_idx[GW-1:0]]) begin
                pick     = rr_idx[GW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Payload muxes and fixed single-beat INCR burst fields.
    assign io_master_araddr  = araddr_i[int'(grant_q)*32 +: 32];
    assign io_master_arsize  = arsize_i[int'(grant_q)*3 +: 3];
    assign io_master_arid    = id_ext;
    assign io_master_arlen   = 8'd0;
    assign io_master_arburst = 2'b01;
    assign io_master_awaddr  = awaddr_i[int'(grant_q)*32 +: 32];
    assign io_master_awsize  = awsize_i[int'(grant_q)*3 +: 3];
    assign io_master_awid    = id_ext;
    assign io_master_awlen   = 8'd0;
    assign io_master_awburst = 2'b01;
    assign io_master_wdata   = wdata_i[int'(grant_q)*DATA_W +: DATA_W];
    assign io_master_wstrb   = wstrb_i[int'(grant_q)*STRB_W +: STRB_W];
    assign io_master_wlast   = 1'b1;

    // A response tagged with another port's ID cannot belong to this
    // transaction, so the requester is told SLVERR instead of the slave's code.
    assign rdata_o = io_master_rdata;
    assign rresp_o = (io_master_rid != id_ext) ? 2'b10 : io_master_rresp;
    assign bresp_o = (io_master_bid != id_ext) ? 2'b10 : io_master_bresp;

    assign r_hs  = io_master_rvalid  & io_master_rready;
    assign aw_hs = io_master_awvalid & io_master_awready;
    assign w_hs  = io_master_wvalid  & io_master_wready;
    assign b_hs  = io_master_bvalid  & io_master_bready;

    // Handshake steering: only the granted port ever sees a valid or ready.
    always_comb begin
        arready_o         = '0;
        rvalid_o          = '0;
        awready_o         = '0;
        wready_o          = '0;
        bvalid_o          = '0;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        case (state_q)
            ST_AR: begin
                io_master_arvalid  = 1'b1;
                arready_o[grant_q] = io_master_arready;
            end
            ST_R: begin
                rvalid_o[grant_q] = io_master_rvalid;
                io_master_rready  = rready_i[grant_q];
            end
            ST_W: begin
                // Each channel stops presenting once its own beat has gone.
                io_master_awvalid  = awvalid_i[grant_q] & ~aw_done_q;
                io_master_wvalid   = wvalid_i[grant_q] & ~w_done_q;
                awready_o[grant_q] = io_master_awready & ~aw_done_q;
                wready_o[grant_q]  = io_master_wready & ~w_done_q;
            end
            ST_B: begin
                bvalid_o[grant_q] = io_master_bvalid;
                io_master_bready  = bready_i[grant_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick;
                    // A port asking for both is served read first.
                    state_d = arvalid_i[pick] ? ST_AR : ST_W;
                end
            end
            ST_AR: begin
                if (io_master_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (r_hs && io_master_rlast) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_inc;
                end
            end
            ST_W: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                if (b_hs) begin
                    state_d   = ST_IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rr_ptr_d  = grant_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Purpose : directed + randomized bench for axi_rr_arbiter with N_PORTS=4, DATA_W=32.
// Latency : checks are taken 2 time units after each rising edge, once inputs have settled.
// Backpress: the bench plays both the upstream requesters and the downstream slave.
module tb_axi_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clock;
    logic reset;

    logic [N-1:0]    arvalid_i, arready_o, rvalid_o, rready_i;
    logic [N-1:0]    awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i;
    logic [N*32-1:0] araddr_i, awaddr_i;
    logic [N*3-1:0]  arsize_i, awsize_i;
    logic [N*DW-1:0] wdata_i;
    logic [N*SW-1:0] wstrb_i;
    logic [DW-1:0]   rdata_o;
    logic [1:0]      rresp_o, bresp_o;

    logic            io_master_awready, io_master_awvalid;
    logic [31:0]     io_master_awaddr;
    logic [3:0]      io_master_awid;
    logic [7:0]      io_master_awlen;
    logic [2:0]      io_master_awsize;
    logic [1:0]      io_master_awburst;
    logic            io_master_wready, io_master_wvalid;
    logic [DW-1:0]   io_master_wdata;
    logic [SW-1:0]   io_master_wstrb;
    logic            io_master_wlast;
    logic            io_master_bready, io_master_bvalid;
    logic [1:0]      io_master_bresp;
    logic [3:0]      io_master_bid;
    logic            io_master_arready, io_master_arvalid;
    logic [31:0]     io_master_araddr;
    logic [3:0]      io_master_arid;
    logic [7:0]      io_master_arlen;
    logic [2:0]      io_master_arsize;
    logic [1:0]      io_master_arburst;
    logic            io_master_rready, io_master_rvalid;
    logic [1:0]      io_master_rresp;
    logic [DW-1:0]   io_master_rdata;
    logic            io_master_rlast;
    logic [3:0]      io_master_rid;

    axi_rr_arbiter #(.N_PORTS(N), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i), .arsize_i(arsize_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i), .awsize_i(awsize_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
        .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
        .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
        .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
        .io_master_awburst(io_master_awburst),
        .io_master_wready(io_master_wready), .io_master_wvalid(io_master_wvalid),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_wlast(io_master_wlast),
        .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
        .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
        .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
        .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
        .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
        .io_master_arburst(io_master_arburst),
        .io_master_rready(io_master_rready), .io_master_rvalid(io_master_rvalid),
        .io_master_rresp(io_master_rresp), .io_master_rdata(io_master_rdata),
        .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks;
    int failures;

    // Reference model: outstanding requests per port and the round-robin pointer.
    bit          pend_rd [N];
    bit          pend_wr [N];
    logic [31:0] q_araddr [N];
    logic [2:0]  q_arsize [N];
    logic [31:0] q_awaddr [N];
    logic [2:0]  q_awsize [N];
    logic [31:0] q_wdata  [N];
    logic [3:0]  q_wstrb  [N];
    int          exp_ptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // First port with a request at or after ptr, counting modulo N.
    function automatic int pick_port(input int ptr);
        for (int k = 0; k < N; k++) begin
            if (pend_rd[(ptr + k) % N] || pend_wr[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic clear_inputs();
        arvalid_i = '0; araddr_i = '0; arsize_i = '0; rready_i = '0;
        awvalid_i = '0; awaddr_i = '0; awsize_i = '0;
        wvalid_i = '0; wdata_i = '0; wstrb_i = '0; bready_i = '0;
        io_master_awready = 1'b0; io_master_wready = 1'b0; io_master_arready = 1'b0;
        io_master_bvalid = 1'b0; io_master_bresp = '0; io_master_bid = '0;
        io_master_rvalid = 1'b0; io_master_rresp = '0; io_master_rdata = '0;
        io_master_rlast = 1'b0; io_master_rid = '0;
    endtask

    task automatic rand_inputs();
        arvalid_i = 4'($urandom); awvalid_i = 4'($urandom); wvalid_i = 4'($urandom);
        rready_i = 4'($urandom); bready_i = 4'($urandom);
        araddr_i = {$urandom, $urandom, $urandom, $urandom};
        awaddr_i = {$urandom, $urandom, $urandom, $urandom};
        wdata_i  = {$urandom, $urandom, $urandom, $urandom};
        arsize_i = 12'($urandom); awsize_i = 12'($urandom); wstrb_i = 16'($urandom);
        io_master_awready = 1'($urandom); io_master_wready = 1'($urandom);
        io_master_arready = 1'($urandom); io_master_bvalid = 1'($urandom);
        io_master_rvalid = 1'($urandom); io_master_rlast = 1'($urandom);
        io_master_rdata = $urandom; io_master_rid = 4'($urandom); io_master_bid = 4'($urandom);
    endtask

    task automatic drive_reqs();
        for (int p = 0; p < N; p++) begin
            arvalid_i[p]         = pend_rd[p];
            awvalid_i[p]         = pend_wr[p];
            wvalid_i[p]          = pend_wr[p];
            araddr_i[p*32 +: 32] = q_araddr[p];
            arsize_i[p*3 +: 3]   = q_arsize[p];
            awaddr_i[p*32 +: 32] = q_awaddr[p];
            awsize_i[p*3 +: 3]   = q_awsize[p];
            wdata_i[p*32 +: 32]  = q_wdata[p];
            wstrb_i[p*4 +: 4]    = q_wstrb[p];
        end
    endtask

    task automatic new_request(input int p, input int kind);
        pend_rd[p]  = (kind != 1);
        pend_wr[p]  = (kind != 0);
        q_araddr[p] = $urandom;
        q_arsize[p] = 3'($urandom_range(0, 2));
        q_awaddr[p] = $urandom;
        q_awsize[p] = 3'($urandom_range(0, 2));
        q_wdata[p]  = $urandom;
        q_wstrb[p]  = 4'($urandom_range(1, 15));
    endtask

    // Entered in an IDLE cycle with requests already driven; leaves in the next IDLE cycle.
    task automatic serve_read(input int g, input logic [31:0] d, input logic [3:0] rid,
                              input logic [1:0] sresp, input int ar_wait, input int r_wait,
                              output int cycles);
        logic [1:0] eresp;
        eresp  = (rid == 4'(g)) ? sresp : 2'b10;
        cycles = 1;
        #1;
        chk("idle_arvalid", io_master_arvalid, 0);
        chk("idle_awvalid", io_master_awvalid, 0);
        tick();
        cycles++;
        for (int c = 0; c <= ar_wait; c++) begin
            io_master_arready = (c == ar_wait);
            #1;
            chk("ar_valid", io_master_arvalid, 1);
            chk("ar_no_aw", io_master_awvalid, 0);
            chk("ar_id", io_master_arid, 4'(g));
            chk("ar_addr", io_master_araddr, q_araddr[g]);
            chk("ar_size", io_master_arsize, q_arsize[g]);
            chk("ar_len_burst", {io_master_arlen, io_master_arburst}, {8'd0, 2'b01});
            chk("ar_ready_o", arready_o, (c == ar_wait) ? (4'b0001 << g) : 4'b0000);
            tick();
            if (c < ar_wait) cycles++;
        end
        cycles++;
        io_master_arready = 1'b0;
        arvalid_i[g]      = 1'b0;
        pend_rd[g]        = 1'b0;
        for (int c = 0; c <= r_wait; c++) begin
            io_master_rvalid = (c == r_wait);
            io_master_rdata  = d;
            io_master_rid    = rid;
            io_master_rresp  = sresp;
            io_master_rlast  = 1'b1;
            rready_i[g]      = 1'b1;
            #1;
            chk("r_valid_o", rvalid_o, (c == r_wait) ? (4'b0001 << g) : 4'b0000);
            chk("r_ready", io_master_rready, 1);
            if (c == r_wait) begin
                chk("r_data", rdata_o, d);
                chk("r_resp", rresp_o, eresp);
            end
            tick();
            if (c < r_wait) cycles++;
        end
        io_master_rvalid = 1'b0;
        rready_i[g]      = 1'b0;
        exp_ptr          = (g + 1) % N;
    endtask

    task automatic serve_write(input int g, input int aw_at, input int w_at, input int b_wait,
                               input logic [3:0] bid, input logic [1:0] sresp);
        logic [1:0] eresp;
        int         n_w;
        eresp = (bid == 4'(g)) ? sresp : 2'b10;
        n_w   = ((aw_at > w_at) ? aw_at : w_at) + 1;
        #1;
        chk("idle_awvalid", io_master_awvalid, 0);
        tick();
        for (int c = 0; c < n_w; c++) begin
            io_master_awready = (c == aw_at);
            io_master_wready  = (c == w_at);
            #1;
            chk("aw_valid", io_master_awvalid, (c <= aw_at));
            chk("w_valid", io_master_wvalid, (c <= w_at));
            chk("w_no_ar", io_master_arvalid, 0);
            chk("aw_ready_o", awready_o, (c == aw_at) ? (4'b0001 << g) : 4'b0000);
            chk("w_ready_o", wready_o, (c == w_at) ? (4'b0001 << g) : 4'b0000);
            if (c <= aw_at) begin
                chk("aw_id", io_master_awid, 4'(g));
                chk("aw_addr", io_master_awaddr, q_awaddr[g]);
                chk("aw_size", io_master_awsize, q_awsize[g]);
                chk("aw_len_burst", {io_master_awlen, io_master_awburst}, {8'd0, 2'b01});
            end
            if (c <= w_at) begin
                chk("w_data", io_master_wdata, q_wdata[g]);
                chk("w_strb", io_master_wstrb, q_wstrb[g]);
                chk("w_last", io_master_wlast, 1);
            end
            tick();
            if (c == aw_at) awvalid_i[g] = 1'b0;
            if (c == w_at)  wvalid_i[g]  = 1'b0;
        end
        io_master_awready = 1'b0;
        io_master_wready  = 1'b0;
        pend_wr[g]        = 1'b0;
        for (int c = 0; c <= b_wait; c++) begin
            io_master_bvalid = (c == b_wait);
            io_master_bid    = bid;
            io_master_bresp  = sresp;
            bready_i[g]      = 1'b1;
            #1;
            chk("b_valid_o", bvalid_o, (c == b_wait) ? (4'b0001 << g) : 4'b0000);
            chk("b_ready", io_master_bready, 1);
            chk("b_no_wvalid", {io_master_awvalid, io_master_wvalid}, 2'b00);
            if (c == b_wait) chk("b_resp", bresp_o, eresp);
            tick();
        end
        io_master_bvalid = 1'b0;
        bready_i[g]      = 1'b0;
        exp_ptr          = (g + 1) % N;
    endtask

    // Serves the next transaction; force_g >= 0 pins the expected grant to a constant.
    task automatic serve_next(input int force_g);
        int         g;
        int         cyc;
        logic [3:0] id;
        g  = (force_g >= 0) ? force_g : pick_port(exp_ptr);
        id = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(g);
        if (pend_rd[g]) begin
            serve_read(g, $urandom, id, 2'($urandom_range(0, 3)),
                       $urandom_range(0, 2), $urandom_range(0, 2), cyc);
        end else begin
            serve_write(g, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                        id, 2'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        int rr_order [5];
        int row_order [3];
        int cyc;
        bit any;
        rr_order  = '{0, 1, 2, 3, 0};
        row_order = '{2, 3, 2};
        checks    = 0;
        failures  = 0;
        exp_ptr   = 0;
        for (int p = 0; p < N; p++) begin
            pend_rd[p] = 0;
            pend_wr[p] = 0;
        end
        clear_inputs();
        reset = 1'b0;

        // Reset held with random activity on every input.
        for (int i = 0; i < 5; i++) begin
            tick();
            rand_inputs();
            #1;
            chk("rst_port_outs", {arready_o, rvalid_o, awready_o, wready_o, bvalid_o}, 20'h0);
            chk("rst_master_outs", {io_master_arvalid, io_master_awvalid, io_master_wvalid,
                                    io_master_rready, io_master_bready}, 5'h0);
        end
        clear_inputs();
        #1;
        reset = 1'b1;
        tick();

        // Round robin with every port reading continuously.
        for (int p = 0; p < N; p++) new_request(p, 0);
        drive_reqs();
        for (int i = 0; i < 5; i++) begin
            serve_next(rr_order[i]);
            new_request(rr_order[i], 0);
            drive_reqs();
        end
        for (int p = 0; p < N; p++) pend_rd[p] = 0;
        drive_reqs();
        tick();

        // Single read on port 1 with a zero-wait slave.
        new_request(1, 0);
        q_araddr[1] = 32'h8000_0004;
        q_arsize[1] = 3'd2;
        drive_reqs();
        serve_read(1, 32'hDEAD_BEEF, 4'd1, 2'b00, 0, 0, cyc);
        chk("rd_latency", cyc, 3);

        // Split write on port 0: AW accepted in W cycle 1, W in W cycle 4.
        new_request(0, 1);
        q_wdata[0] = 32'h1234_5678;
        q_wstrb[0] = 4'b0011;
        drive_reqs();
        serve_write(0, 1, 4, 2, 4'd0, 2'b00);

        // Read-over-write on port 2 while port 3 waits with a write.
        new_request(2, 2);
        new_request(3, 1);
        drive_reqs();
        for (int i = 0; i < 3; i++) begin
            serve_next(row_order[i]);
            drive_reqs();
        end

        // Response tagged with port 3's ID while port 1 owns the bus.
        new_request(1, 0);
        drive_reqs();
        serve_read(1, $urandom, 4'd3, 2'b00, 0, 1, cyc);

        // Reset asserted while a read sits in R.
        new_request(1, 0);
        drive_reqs();
        tick();
        io_master_arready = 1'b1;
        #1;
        chk("rstR_ar_id", io_master_arid, 4'd1);
        tick();
        io_master_arready = 1'b0;
        arvalid_i[1]      = 1'b0;
        pend_rd[1]        = 0;
        io_master_rvalid  = 1'b1;
        io_master_rlast   = 1'b1;
        io_master_rid     = 4'd1;
        rready_i[1]       = 1'b1;
        #1;
        chk("rstR_pre_rvalid", rvalid_o, 4'b0010);
        reset = 1'b0;
        #1;
        chk("rstR_rvalid", rvalid_o, 4'b0000);
        chk("rstR_master", {io_master_rready, io_master_arvalid, io_master_awvalid}, 3'b000);
        clear_inputs();
        tick();
        reset   = 1'b1;
        exp_ptr = 0;
        tick();

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            any = 0;
            for (int p = 0; p < N; p++) begin
                if (!pend_rd[p] && !pend_wr[p] && $urandom_range(0, 2) != 0) begin
                    new_request(p, $urandom_range(0, 2));
                end
                if (pend_rd[p] || pend_wr[p]) any = 1;
            end
            if (!any) new_request($urandom_range(0, N - 1), 0);
            drive_reqs();
            serve_next(-1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
